uart_rx_push: RTL
=================

UART_RX_PUSH -- requirements
Module: uart_rx_push

Interface
REQ-001 Parameter CLK_PER_BIT, default `UART_CLK_PER_BIT, is the number of clk cycles per serial bit and SHALL be at least 8.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rstn  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 rxd  input  1  asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-005 push_order  output  1  write request to the downstream byte ring buffer.
REQ-006 push_data  output  8  byte to write; valid whenever push_order=1.
REQ-007 push_done  input  1  buffer acknowledge, arriving one cycle after an accepted push_order.
REQ-008 overrun  output  1  one-cycle pulse when a received byte is dropped.
REQ-009 frame_err  output  1  one-cycle pulse when a stop bit samples low.

Function
REQ-010 rxd SHALL pass through a 2-flop synchronizer; all receive logic SHALL use the synchronized value rx_s.
REQ-011 The receive FSM SHALL have the states R_IDLE, R_START, R_DATA, R_STOP and R_BREAK, plus one bit counter (3 bits) and one cycle counter wide enough for CLK_PER_BIT-1.
REQ-012 R_IDLE: when rx_s=0, the FSM SHALL clear the cycle counter and go to R_START.
REQ-013 R_START: after CLK_PER_BIT/2 cycles it SHALL sample rx_s; 0 goes to R_DATA with the bit counter at 0; 1 (a glitch) returns to R_IDLE with no pulse.
REQ-014 R_DATA: every CLK_PER_BIT cycles it SHALL sample rx_s into shift[bitcnt], LSB first; after bit 7 it goes to R_STOP.
REQ-015 R_STOP: after CLK_PER_BIT cycles it SHALL sample rx_s.
  - 1: byte complete, return to R_IDLE.
  - 0: pulse frame_err, discard the byte, go to R_BREAK.
REQ-016 R_BREAK: the FSM SHALL stay until rx_s=1, then go to R_IDLE.
REQ-017 The push side SHALL have a pending flag, an 8-bit hold register and the states P_IDLE, P_REQ and P_WAIT.
REQ-018 Byte complete while pending=0: the byte SHALL be loaded into hold, pending set, and P_REQ entered on the next cycle.
REQ-019 P_REQ: push_order=1 for exactly one cycle with push_data=hold, then go to P_WAIT.
REQ-020 P_WAIT: push_order=0.
  - push_done=1: clear pending, go to P_IDLE.
  - push_done=0 (buffer full): go back to P_REQ.
REQ-021 push_order SHALL never be high on two consecutive cycles, so the buffer cannot double-write.
REQ-022 Latency: push_order SHALL rise exactly 2 cycles after the stop-bit sample edge when pending was clear.
REQ-023 Byte complete while pending=1: the new byte SHALL be dropped, overrun pulses one cycle, and hold is unchanged.
REQ-024 The receive FSM SHALL never stall; receiving continues regardless of push-side state.
REQ-025 Byte completion in the same cycle that P_WAIT sees push_done=1 SHALL count as pending=1: overrun, byte dropped.
REQ-026 push_data SHALL equal hold at all times.

Reset
REQ-027 rstn=0 at a clock edge SHALL set the following, aborting any frame or push in progress:
  - R_IDLE, P_IDLE, pending=0;
  - counters=0, shift=0, hold=0;
  - push_order=0, overrun=0, frame_err=0;
  - both synchronizer flops=1.
REQ-028 After reset release, a line held low SHALL be treated as a start edge only after rx_s has propagated low; no pulse is produced from reset itself.

Structure
REQ-029 `UART_CLK_PER_BIT SHALL be defined in include.vh beside the other shared lengths; FSM encodings stay local localparams.
REQ-030 No sub-module is required; the synchronizer and both FSMs live in uart_rx_push, with an optional sub-module sync2 for the synchronizer.

Verification (CLK_PER_BIT=16, buffer model acks one cycle after push_order unless full)
REQ-031 Serial byte 0xA5 with a correct stop bit -> one push_order cycle with push_data=0xA5, push_done next cycle, no pulses.
REQ-032 rxd low for 4 cycles, then high -> FSM returns to R_IDLE; no push, no frame_err.
REQ-033 Frame 0x3C with stop bit low, then line high -> frame_err pulses once, no push, next frame 0x11 pushed normally.
REQ-034 Buffer model full (push_done=0) for 3 attempts, then free -> push_order pulses on alternating cycles, 0x5A written once, pending then cleared.
REQ-035 Buffer stuck full, bytes 0x01 then 0x02 sent back-to-back -> overrun pulses once, and after release only 0x01 is pushed.
REQ-036 rstn asserted mid-R_DATA of 0xFF -> no push; a following 0x42 frame is pushed correctly.

Source files
------------

// File: rtl/uart_rx_push_pkg.sv
// Shared widths and helpers for the UART byte receiver / ring-buffer pusher.
package uart_rx_push_pkg;

  localparam int BYTE_W   = 8;
  localparam int BITCNT_W = 3;

  // Width of a counter that must hold clk_per_bit-1.
  function automatic int cnt_width(input int clk_per_bit);
    return (clk_per_bit > 2) ? $clog2(clk_per_bit) : 1;
  endfunction

endpackage

// File: rtl/include.vh
// Shared lengths used across the UART receive path.
`ifndef UART_INCLUDE_VH
`define UART_INCLUDE_VH

// clk cycles per serial bit; must be at least 8
`define UART_CLK_PER_BIT 16

// payload bits per 8N1 frame
`define UART_DATA_BITS 8

`endif

// File: rtl/uart_rx_push_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports:
//   clk  - clock
//   rstn - synchronous active-low reset; both flops reset to the idle (high) level
//   d    - asynchronous input
//   q    - synchronized output
module uart_rx_push_sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx_push.sv
// 8N1 UART receiver that forwards each received byte to a downstream ring
// buffer through a push_order / push_done handshake. A byte that completes
// while the previous one is still waiting for acceptance is dropped.
// Ports:
//   clk        - clock
//   rstn       - synchronous active-low reset
//   rxd        - asynchronous serial input, idles high, LSB first
//   push_order - one-cycle write request to the buffer
//   push_data  - byte to write (always equals the hold register)
//   push_done  - buffer acknowledge, one cycle after an accepted push_order
//   overrun    - one-cycle pulse when a received byte is dropped
//   frame_err  - one-cycle pulse when the stop bit samples low
`include "include.vh"

module uart_rx_push
  import uart_rx_push_pkg::*;
#(
  parameter int CLK_PER_BIT = `UART_CLK_PER_BIT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  output logic              push_order,
  output logic [BYTE_W-1:0] push_data,
  input  logic              push_done,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = cnt_width(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_REQ,
    P_WAIT
  } push_state_t;

  logic                rx_s;
  rx_state_t           rx_state;
  logic [CNT_W-1:0]    cnt;
  logic [BITCNT_W-1:0] bitcnt;
  logic [BYTE_W-1:0]   shift;
  logic                byte_vld_p0;

  push_state_t         p_state;
  logic                pending;
  logic [BYTE_W-1:0]   hold;

  // ---- stage: line synchronization ----
  uart_rx_push_sync2 u_sync2 (
    .clk  (clk),
    .rstn (rstn),
    .d    (rxd),
    .q    (rx_s)
  );

  // ---- stage: receive FSM (never stalls on the push side) ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state    <= R_IDLE;
      cnt         <= '0;
      bitcnt      <= '0;
      shift       <= '0;
      byte_vld_p0 <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_vld_p0 <= 1'b0;
      frame_err   <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (!rx_s) begin
            cnt      <= '0;
            rx_state <= R_START;
          end
        end
        R_START: begin
          // Re-check the line mid start bit; a high level means a glitch.
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            bitcnt   <= '0;
            rx_state <= rx_s ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        R_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt           <= '0;
            shift[bitcnt] <= rx_s;
            if (bitcnt == BITCNT_W'(BYTE_W - 1)) begin
              rx_state <= R_STOP;
            end else begin
              bitcnt <= bitcnt + BITCNT_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        R_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              byte_vld_p0 <= 1'b1;
              rx_state    <= R_IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_state  <= R_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        R_BREAK: begin
          if (rx_s) begin
            rx_state <= R_IDLE;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // ---- stage: hold register and push handshake ----
  // pending is tested before any clear in the same cycle, so a byte that
  // completes while P_WAIT is being acknowledged is still an overrun.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      p_state    <= P_IDLE;
      pending    <= 1'b0;
      hold       <= '0;
      push_order <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (byte_vld_p0) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          hold    <= shift;
          pending <= 1'b1;
        end
      end
      case (p_state)
        P_IDLE: begin
          if (pending) begin
            p_state    <= P_REQ;
            push_order <= 1'b1;
          end
        end
        P_REQ: begin
          push_order <= 1'b0;
          p_state    <= P_WAIT;
        end
        P_WAIT: begin
          if (push_done) begin
            pending <= 1'b0;
            p_state <= P_IDLE;
          end else begin
            p_state    <= P_REQ;
            push_order <= 1'b1;
          end
        end
        default: begin
          p_state    <= P_IDLE;
          push_order <= 1'b0;
        end
      endcase
    end
  end

  assign push_data = hold;

endmodule
